// File: rtl/hamm_pkg.sv
// Shared Hamming layout helpers: parity at power-of-two positions, data fills the rest ascending.
package hamm_pkg;

    localparam int unsigned CNT_W = 16;

    function automatic logic is_pow2(input int unsigned pos);
        return (pos != 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position (1-based) of data bit idx.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned pos;
        int unsigned seen;
        logic        found;
        pos   = 0;
        seen  = 0;
        found = 1'b0;
        for (int unsigned p = 1; p < 1024; p++) begin
            if (!found && !is_pow2(p)) begin
                if (seen == idx) begin
                    pos   = p;
                    found = 1'b1;
                end
                seen++;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamm_enc_core.sv
// Combinational k-to-n Hamming scatter plus even parity; out bit i holds position i+1.
module hamm_enc_core
    import hamm_pkg::*;
#(
    parameter int unsigned n = 7,
    parameter int unsigned k = 4
) (
    input  logic [k-1:0] data,
    output logic [n-1:0] code
);

    logic [n-1:0] w;
    logic [n-1:0] m;

    always_comb begin
        w = '0;
        m = '0;
        for (int unsigned i = 0; i < k; i++) begin
            w = w | (n'(data[i]) << (data_pos(i) - 1));
        end
        // Parity positions never appear in each other's masks, so order is irrelevant.
        for (int unsigned l = 0; l < n - k; l++) begin
            m = '0;
            for (int unsigned p = 1; p <= n; p++) begin
                if ((((p >> l) & 1) == 1) && (p != (1 << l))) begin
                    m = m | (n'(1) << (p - 1));
                end
            end
            w = w | (n'(^(w & m)) << ((1 << l) - 1));
        end
        code = w;
    end

endmodule

// File: rtl/hamm_enc_pipe.sv
// Two-stage valid/ready Hamming encoder pipeline with delivered-word counter.
// Optional single-bit error injection via HAMM_ERR_INJ_EN.
module hamm_enc_pipe
    import hamm_pkg::*;
#(
    parameter int unsigned n = 7,
    parameter int unsigned k = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [k-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [n-1:0]     out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt
`ifdef HAMM_ERR_INJ_EN
    ,
    input  logic [n-k-1:0]   err_pos
`endif
);

    logic         s1_v;
    logic         s2_v;
    logic [k-1:0] s1_data;
    logic [n-1:0] enc_code;
    logic [n-1:0] nxt_code;
    logic         s1_load;
    logic         s2_load;

    assign s2_load   = ~s2_v | out_ready;
    assign s1_load   = ~s1_v | s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_v;

    hamm_enc_core #(.n(n), .k(k)) u_core (
        .data (s1_data),
        .code (enc_code)
    );

`ifdef HAMM_ERR_INJ_EN
    logic [n-k-1:0] s1_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_err <= '0;
        end else if (s1_load && in_valid) begin
            s1_err <= err_pos;
        end
    end

    always_comb begin
        nxt_code = enc_code;
        if ((s1_err != '0) && (32'(s1_err) <= n)) begin
            nxt_code = enc_code ^ (n'(1) << (s1_err - 1'b1));
        end
    end
`else
    assign nxt_code = enc_code;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_data <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v     <= 1'b0;
            out_code <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_code <= nxt_code;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (s2_v && out_ready) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule
